mhsa_seq: RTL



---
 rtl/mhsa_pkg.sv | 27 ++
 rtl/mhsa_seq_if.sv | 29 ++
 rtl/seq_fifo2.sv | 66 ++++++
 rtl/mhsa_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mhsa_pkg.sv
// mhsa_pkg: shared types and constants for the MHSA job sequencer.
//   seq_state_e   : sequencer FSM state encoding
//   CSR_*_OFS     : byte offsets of the sequencer CSRs in the host map
//   DATA_W        : usram / engine data width
//   byte_to_word  : byte address to 64-bit word address
package mhsa_pkg;

    localparam int DATA_W = 64;

    localparam logic [15:0] CSR_START_OFS    = 16'h4000;
    localparam logic [15:0] CSR_IN_BASE_OFS  = 16'h4004;
    localparam logic [15:0] CSR_OUT_BASE_OFS = 16'h4008;
    localparam logic [15:0] CSR_STATUS_OFS   = 16'h400c;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        STORE,
        FIN
    } seq_state_e;

    function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr);
        return {3'b000, byte_addr[31:3]};
    endfunction

endpackage

// File: rtl/mhsa_seq_if.sv
// mhsa_seq_if: shared usram port between the sequencer and the arbiter.
//   rd_req/rd_addr/rd_gnt/rd_data : read request, grant, data one cycle after grant
//   wr_req/wr_addr/wr_data/wr_gnt : write request and grant
//   master modport = sequencer side, slave modport = usram/arbiter side
interface mhsa_seq_if #(
    parameter int AW = 16
);
    import mhsa_pkg::*;

    logic              rd_req;
    logic [AW-1:0]     rd_addr;
    logic              rd_gnt;
    logic [DATA_W-1:0] rd_data;
    logic              wr_req;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_gnt, rd_data, wr_gnt
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_gnt, rd_data, wr_gnt
    );

endinterface

// File: rtl/seq_fifo2.sv
// seq_fifo2: 2-entry 64-bit FIFO with valid/ready on both sides.
//   in_valid/in_ready/in_data    : push side
//   out_valid/out_ready/out_data : pop side, head is registered
//   count                        : current occupancy (0..2)
module seq_fifo2
    import mhsa_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);
    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mhsa_seq.sv
// mhsa_seq: MHSA job sequencer. Streams LOAD_WORDS words from usram into the
// engine, waits for engine completion, writes STORE_WORDS results back.
//   clk, rst                  : clock, synchronous active-high reset
//   start[0]                  : job command, rising edge in IDLE starts a job
//   input_base, output_base   : byte addresses of the input/output blocks
//   done, busy                : job status
//   mem                       : usram port (mhsa_seq_if.master)
//   eng_*                     : engine kick, input stream, done pulse, result stream
//   perf_cycles               : busy-cycle counter, only with MHSA_SEQ_PERF_EN defined
//
//   state   | meaning
//   IDLE    | waiting for a start edge
//   LOAD    | reading input words into the engine
//   COMPUTE | waiting for engine done
//   STORE   | writing result words back
//   FIN     | job finished, done raised
module mhsa_seq
    import mhsa_pkg::*;
#(
    parameter int LOAD_WORDS  = 64,
    parameter int STORE_WORDS = 64,
    parameter int AW          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       start,
    input  logic [31:0]       input_base,
    input  logic [31:0]       output_base,
    output logic              done,
    output logic              busy,
    mhsa_seq_if.master        mem,
    output logic              eng_start,
    output logic              eng_in_valid,
    output logic [DATA_W-1:0] eng_in_data,
    input  logic              eng_in_ready,
    input  logic              eng_done,
    input  logic              eng_out_valid,
    input  logic [DATA_W-1:0] eng_out_data,
    output logic              eng_out_ready
`ifdef MHSA_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);
    localparam int LCW = $clog2(LOAD_WORDS + 1);
    localparam int SCW = $clog2(STORE_WORDS + 1);
    localparam logic [LCW-1:0] LOAD_N  = LCW'(LOAD_WORDS);
    localparam logic [SCW-1:0] STORE_N = SCW'(STORE_WORDS);

    seq_state_e        state_q, state_d;
    logic              start_prev_q, start_prev_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              eng_start_q, eng_start_d;
    logic [AW-1:0]     in_base_q, in_base_d;
    logic [AW-1:0]     out_base_q, out_base_d;
    logic [LCW-1:0]    issued_q, issued_d;
    logic [LCW-1:0]    consumed_q, consumed_d;
    logic              inflight_q, inflight_d;
    logic              eng_done_seen_q, eng_done_seen_d;
    logic [SCW-1:0]    accepted_q, accepted_d;
    logic [SCW-1:0]    stored_q, stored_d;
    logic              ob_valid_q, ob_valid_d;
    logic [DATA_W-1:0] ob_data_q, ob_data_d;
`ifdef MHSA_SEQ_PERF_EN
    logic [31:0]       perf_q, perf_d;
`endif

    logic [31:0] in_word, out_word;
    logic        start_edge;
    logic        rd_req_w, rd_fire, in_fire, wr_req_w, wr_fire, cap_fire, out_rdy_w;
    logic        fifo_in_ready, fifo_out_valid;
    logic [1:0]  fifo_count;
    logic        unused_bits;

    assign in_word     = byte_to_word(input_base);
    assign out_word    = byte_to_word(output_base);
    assign unused_bits = ^{start[31:1], in_word[31:AW], out_word[31:AW], fifo_in_ready};
    assign start_edge  = start[0] & ~start_prev_q;

    // Request only while the FIFO can still absorb everything already granted,
    // so the FIFO never overflows regardless of grant/ready patterns.
    assign rd_req_w = (state_q == LOAD) && (issued_q < LOAD_N) &&
                      (({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd2);
    assign rd_fire  = rd_req_w & mem.rd_gnt;

    assign eng_in_valid = (state_q == LOAD) && fifo_out_valid;
    assign in_fire      = eng_in_valid & eng_in_ready;

    assign wr_req_w = (state_q == STORE) && ob_valid_q;
    assign wr_fire  = wr_req_w & mem.wr_gnt;
    // A grant frees the output register this cycle, allowing 1 word/cycle.
    assign out_rdy_w = (state_q == STORE) && (accepted_q < STORE_N) &&
                       (!ob_valid_q || mem.wr_gnt);
    assign cap_fire  = out_rdy_w & eng_out_valid;

    seq_fifo2 u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inflight_q),
        .in_ready  (fifo_in_ready),
        .in_data   (mem.rd_data),
        .out_valid (fifo_out_valid),
        .out_ready (eng_in_ready && (state_q == LOAD)),
        .out_data  (eng_in_data),
        .count     (fifo_count)
    );

    assign mem.rd_req  = rd_req_w;
    assign mem.rd_addr = in_base_q + AW'(issued_q);
    assign mem.wr_req  = wr_req_w;
    assign mem.wr_addr = out_base_q + AW'(stored_q);
    assign mem.wr_data = ob_data_q;

    assign done          = done_q;
    assign busy          = busy_q;
    assign eng_start     = eng_start_q;
    assign eng_out_ready = out_rdy_w;
`ifdef MHSA_SEQ_PERF_EN
    assign perf_cycles   = perf_q;
`endif

    always_comb begin
        state_d         = state_q;
        start_prev_d    = start[0];
        done_d          = done_q;
        busy_d          = busy_q;
        eng_start_d     = 1'b0;
        in_base_d       = in_base_q;
        out_base_d      = out_base_q;
        issued_d        = issued_q;
        consumed_d      = consumed_q;
        inflight_d      = rd_fire;
        eng_done_seen_d = eng_done_seen_q;
        accepted_d      = accepted_q;
        stored_d        = stored_q;
        ob_valid_d      = ob_valid_q;
        ob_data_d       = ob_data_q;
`ifdef MHSA_SEQ_PERF_EN
        perf_d = perf_q;
        if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
`endif
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d         = LOAD;
                    done_d          = 1'b0;
                    busy_d          = 1'b1;
                    eng_start_d     = 1'b1;
                    in_base_d       = in_word[AW-1:0];
                    out_base_d      = out_word[AW-1:0];
                    issued_d        = '0;
                    consumed_d      = '0;
                    accepted_d      = '0;
                    stored_d        = '0;
                    eng_done_seen_d = 1'b0;
`ifdef MHSA_SEQ_PERF_EN
                    perf_d = '0;
`endif
                end
            end
            LOAD: begin
                if (rd_fire)  issued_d   = issued_q + LCW'(1);
                if (in_fire)  consumed_d = consumed_q + LCW'(1);
                if (eng_done) eng_done_seen_d = 1'b1;
                if (consumed_d == LOAD_N) state_d = COMPUTE;
            end
            COMPUTE: begin
                if (eng_done || eng_done_seen_q) begin
                    state_d         = STORE;
                    eng_done_seen_d = 1'b0;
                end
            end
            STORE: begin
                if (wr_fire) begin
                    stored_d   = stored_q + SCW'(1);
                    ob_valid_d = 1'b0;
                end
                if (cap_fire) begin
                    accepted_d = accepted_q + SCW'(1);
                    ob_valid_d = 1'b1;
                    ob_data_d  = eng_out_data;
                end
                if (stored_d == STORE_N) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            start_prev_q    <= 1'b0;
            done_q          <= 1'b0;
            busy_q          <= 1'b0;
            eng_start_q     <= 1'b0;
            in_base_q       <= '0;
            out_base_q      <= '0;
            issued_q        <= '0;
            consumed_q      <= '0;
            inflight_q      <= 1'b0;
            eng_done_seen_q <= 1'b0;
            accepted_q      <= '0;
            stored_q        <= '0;
            ob_valid_q      <= 1'b0;
            ob_data_q       <= '0;
`ifdef MHSA_SEQ_PERF_EN
            perf_q          <= '0;
`endif
        end else begin
            state_q         <= state_d;
            start_prev_q    <= start_prev_d;
            done_q          <= done_d;
            busy_q          <= busy_d;
            eng_start_q     <= eng_start_d;
            in_base_q       <= in_base_d;
            out_base_q      <= out_base_d;
            issued_q        <= issued_d;
            consumed_q      <= consumed_d;
            inflight_q      <= inflight_d;
            eng_done_seen_q <= eng_done_seen_d;
            accepted_q      <= accepted_d;
            stored_q        <= stored_d;
            ob_valid_q      <= ob_valid_d;
            ob_data_q       <= ob_data_d;
`ifdef MHSA_SEQ_PERF_EN
            perf_q          <= perf_d;
`endif
        end
    end

endmodule
